root_square: RTL and testbench

Iterative squarer-and-adder that reconstructs a 32-bit radicand from a 16-bit root and 17-bit remainder: d = q*q + r. It is the inverse companion of the team's 16-cycle restoring square-root unit. It shares that unit's load/busy/ready/count handshake, so the two can be chained for round-trip checking or used standalone in the datapath. One multiplier bit is processed per clock, MSB first, in 16 busy cycles.

---
 rtl/root_pkg.sv | 17 +
 rtl/root_square_step.sv | 23 ++
 rtl/root_square.sv | 95 +++++++++
 tb/tb_root_square.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/root_pkg.sv
// rtl/root_pkg.sv - shared widths and control states for the root/square units
package root_pkg;

  localparam int ROOT_W = 16;
  localparam int RAD_W  = 32;
  localparam int REM_W  = 17;
  localparam int CNT_W  = 4;
  localparam int ACC_W  = RAD_W + 1;

  localparam logic [CNT_W-1:0] CNT_LAST = 4'hf;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } root_state_t;

endpackage

// File: rtl/root_square_step.sv
// rtl/root_square_step.sv - one MSB-first shift-and-add step of q*q + r
module root_square_step
  import root_pkg::*;
(
  input  logic [ACC_W-1:0]  p,
  input  logic              b_msb,
  input  logic [ROOT_W-1:0] m,
  input  logic [REM_W-1:0]  r,
  input  logic              last,
  output logic [ACC_W-1:0]  p_next
);

  logic [ACC_W-1:0] add_m;
  logic [ACC_W-1:0] add_r;

  // Partial product for this multiplier bit, plus the remainder folded in on the final step
  always_comb begin
    add_m  = b_msb ? {{(ACC_W-ROOT_W){1'b0}}, m} : '0;
    add_r  = last  ? {{(ACC_W-REM_W){1'b0}}, r}  : '0;
    p_next = {p[ACC_W-2:0], 1'b0} + add_m + add_r;
  end

endmodule

// File: rtl/root_square.sv
// rtl/root_square.sv - iterative d = q*q + r, 16 busy cycles; ROOT_CHECK_EN adds valid output
module root_square
  import root_pkg::*;
(
  input  logic              clk,
  input  logic              clrn,
  input  logic [ROOT_W-1:0] q,
  input  logic [REM_W-1:0]  r,
  input  logic              load,
  output logic [RAD_W-1:0]  d,
  output logic              carry,
  output logic              busy,
  output logic              ready,
  output logic [CNT_W-1:0]  count
`ifdef ROOT_CHECK_EN
  ,
  output logic              valid
`endif
);

  root_state_t       state;
  logic [ROOT_W-1:0] reg_m;
  logic [ROOT_W-1:0] reg_b;
  logic [REM_W-1:0]  reg_r;
  logic [ACC_W-1:0]  reg_p;
  logic [ACC_W-1:0]  p_next;
  logic              last_step;

  assign last_step = (count == CNT_LAST);

  root_square_step u_step (
    .p      (reg_p),
    .b_msb  (reg_b[ROOT_W-1]),
    .m      (reg_m),
    .r      (reg_r),
    .last   (last_step),
    .p_next (p_next)
  );

  // Datapath and control: load restarts, each running cycle consumes one multiplier bit
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state <= ST_IDLE;
      reg_m <= '0;
      reg_b <= '0;
      reg_r <= '0;
      reg_p <= '0;
      count <= '0;
      busy  <= 1'b0;
      ready <= 1'b0;
    end else if (load) begin
      state <= ST_RUN;
      reg_m <= q;
      reg_b <= q;
      reg_r <= r;
      reg_p <= '0;
      count <= '0;
      busy  <= 1'b1;
      ready <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          reg_p <= p_next;
          reg_b <= {reg_b[ROOT_W-2:0], 1'b0};
          if (last_step) begin
            state <= ST_IDLE;
            count <= '0;
            busy  <= 1'b0;
            ready <= 1'b1;
          end else begin
            count <= count + 4'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef ROOT_CHECK_EN
  // Remainder legality flag captured at load: r <= 2*q, as an 18-bit compare
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= ({1'b0, r} <= {1'b0, q, 1'b0});
    end
  end
`endif

  assign d     = reg_p[RAD_W-1:0];
  assign carry = reg_p[RAD_W];

endmodule

// File: tb/tb_root_square.sv
// tb/tb_root_square.sv - self-checking bench for root_square
module tb_root_square;

  logic        clk;
  logic        clrn;
  logic [15:0] q;
  logic [16:0] r;
  logic        load;
  logic [31:0] d;
  logic        carry;
  logic        busy;
  logic        ready;
  logic [3:0]  count;
`ifdef ROOT_CHECK_EN
  logic        valid;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  root_square dut (
    .clk   (clk),
    .clrn  (clrn),
    .q     (q),
    .r     (r),
    .load  (load),
    .d     (d),
    .carry (carry),
    .busy  (busy),
    .ready (ready),
    .count (count)
`ifdef ROOT_CHECK_EN
    ,
    .valid (valid)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Load at the current negedge, then check the 16-cycle latency, count walk and result
  task automatic run_op(input logic [15:0] qi, input logic [16:0] ri, input string tag);
    longint unsigned full;
    logic [32:0]     e;
    full = longint'(qi) * longint'(qi) + longint'(ri);
    e    = full[32:0];
    q    = qi;
    r    = ri;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    q    = 16'($urandom);
    r    = 17'($urandom);
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk);
      check({tag, "_count"}, 64'(count), 64'(k));
      check({tag, "_early_ready"}, 64'(ready), 64'd0);
    end
    @(negedge clk);
    check({tag, "_ready"}, 64'(ready), 64'd1);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_count_wrap"}, 64'(count), 64'd0);
    check({tag, "_d"}, 64'(d), 64'(e[31:0]));
    check({tag, "_carry"}, 64'(carry), 64'(e[32]));
`ifdef ROOT_CHECK_EN
    check({tag, "_valid"}, 64'(valid), 64'((int'(ri) <= 2 * int'(qi)) ? 1 : 0));
`endif
    @(negedge clk);
    check({tag, "_ready_hold"}, 64'(ready), 64'd1);
  endtask

  task automatic wait_count(input logic [3:0] target, input string tag);
    int t;
    t = 0;
    while (count !== target && t < 40) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_reach_count"}, 64'(count), 64'(target));
  endtask

  initial begin
    clrn = 1'b0;
    load = 1'b0;
    q    = '0;
    r    = '0;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_d", 64'(d), 64'd0);
    check("rst_carry", 64'(carry), 64'd0);
`ifdef ROOT_CHECK_EN
    check("rst_valid", 64'(valid), 64'd0);
`endif
    @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);

    run_op(16'h0000, 17'h00000, "zero");
    run_op(16'h1234, 17'h00005, "h1234");
    check("h1234_const", 64'(d), 64'h014B5A95);
    run_op(16'hFFFF, 17'h1FFFE, "max_legal");
    check("max_legal_const", 64'(d), 64'hFFFFFFFF);
    run_op(16'hFFFF, 17'h1FFFF, "overflow");
    check("overflow_carry_const", 64'(carry), 64'd1);

    // Restart mid-operation
    q = 16'd3; r = 17'd1; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_count(4'd7, "restart");
    run_op(16'd10, 17'd20, "restart");
    check("restart_const", 64'(d), 64'd120);

    // Load held high keeps restarting
    q = 16'd7; r = 17'd2; load = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 19) begin
        check("hold_busy", 64'(busy), 64'd1);
        check("hold_count", 64'(count), 64'd0);
        check("hold_ready", 64'(ready), 64'd0);
      end
    end
    run_op(16'd7, 17'd2, "after_hold");

    // Reset mid-operation
    q = 16'd3; r = 17'd1; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_count(4'd5, "midrst");
    clrn = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_ready", 64'(ready), 64'd0);
    check("midrst_count", 64'(count), 64'd0);
    check("midrst_d", 64'(d), 64'd0);
    @(negedge clk);
    @(negedge clk);
    clrn = 1'b1;
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 24; k++) begin
        @(negedge clk);
        if (ready === 1'b1 || busy === 1'b1) seen++;
      end
      check("midrst_no_ready", 64'(seen), 64'd0);
    end
    run_op(16'd2, 17'd1, "post_rst");
    check("post_rst_const", 64'(d), 64'd5);

    // Randomized operands against the arithmetic model
    for (int i = 0; i < 24; i++) begin
      logic [15:0] rq;
      logic [16:0] rr;
      rq = 16'($urandom);
      rr = 17'($urandom);
      if (i % 3 == 0) rr = 17'($urandom_range(0, 2 * int'(rq)));
      run_op(rq, rr, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
